// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant in IDLE, one memory access
// in ACCESS, registered Ack/Err/RData in RESP (one access every three cycles).
module dmem_arbiter #(
   parameter int MEM_BYTES = 131072
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        We0,
   input  logic        We1,
   input  logic [31:0] Addr0,
   input  logic [31:0] Addr1,
   input  logic [31:0] WData0,
   input  logic [31:0] WData1,
   output logic        Ack0,
   output logic        Ack1,
   output logic        Err0,
   output logic        Err1,
   output logic [31:0] RData0,
   output logic [31:0] RData1,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [31:0] MemReadData,
   output logic        Busy
);

   localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        last;
   logic        grant;
   logic        start;
   logic        we_p1;
   logic        idx_p1;
   logic        rej_p1;
   logic [31:0] sel_addr;
   logic [31:0] rd_val;

   function automatic logic is_rejected(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr >= LIMIT);
   endfunction

   function automatic logic [31:0] read_word(input logic rej, input logic [31:0] data);
      return rej ? 32'h0 : data;
   endfunction

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Busy      = (state != IDLE);
      // On a tie the requester that was not served last wins.
      if (Req0 && Req1) grant = ~last;
      else              grant = Req1;
      case (state)
         IDLE:    if (Req0 || Req1) state_nxt = ACCESS;
         ACCESS: begin
            state_nxt = RESP;
            MemRead   = ~we_p1 & ~rej_p1;
            MemWrite  =  we_p1 & ~rej_p1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign start    = (state == IDLE) && (Req0 || Req1);
   assign sel_addr = grant ? Addr1 : Addr0;
   assign rd_val   = read_word(rej_p1, MemReadData);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (start) last <= grant;
      end
   end

   // Stage boundary: winner's request latched on IDLE->ACCESS.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         we_p1        <= 1'b0;
         idx_p1       <= 1'b0;
         rej_p1       <= 1'b0;
         MemAddress   <= 32'h0;
         MemWriteData <= 32'h0;
      end else if (start) begin
         we_p1        <= grant ? We1 : We0;
         idx_p1       <= grant;
         rej_p1       <= is_rejected(sel_addr);
         MemAddress   <= sel_addr;
         MemWriteData <= grant ? WData1 : WData0;
      end
   end

   // Stage boundary: response registered on ACCESS->RESP.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Ack0   <= 1'b0;
         Ack1   <= 1'b0;
         Err0   <= 1'b0;
         Err1   <= 1'b0;
         RData0 <= 32'h0;
         RData1 <= 32'h0;
      end else begin
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
         Err0 <= 1'b0;
         Err1 <= 1'b0;
         if (state == ACCESS) begin
            if (idx_p1) begin
               Ack1 <= 1'b1;
               Err1 <= rej_p1;
            end else begin
               Ack0 <= 1'b1;
               Err0 <= rej_p1;
            end
            if (!we_p1) begin
               if (idx_p1) RData1 <= rd_val;
               else        RData0 <= rd_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-addressed memory model and
// hand-computed expectations.
module tb_dmem_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
   logic [31:0] Addr0 = '0, Addr1 = '0, WData0 = '0, WData1 = '0;
   logic        Ack0, Ack1, Err0, Err1, MemWrite, MemRead, Busy;
   logic [31:0] RData0, RData1, MemAddress, MemWriteData, MemReadData;

   bit   [31:0] mem [0:32767];
   logic        pre_en = 1'b0;
   logic [14:0] pre_idx = '0;
   logic [31:0] pre_val = '0;

   int n_chk = 0;
   int n_err = 0;

   logic        acc_rd, acc_wr, acc_busy;
   logic [31:0] acc_addr;
   logic        r_ack0, r_ack1, r_err0, r_err1;
   logic [31:0] r_rdata0, r_rdata1;
   logic        idle_busy;
   logic [1:0]  idle_ack;
   int          mw_cyc;

   int   ev_who [0:7];
   int   ev_cyc [0:7];
   int   n_ev;
   int   both_seen;
   int   ack_cnt;

   dmem_arbiter #(.MEM_BYTES(131072)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
      .RData0(RData0), .RData1(RData1),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData),
      .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (pre_en)        mem[pre_idx] <= pre_val;
      else if (MemWrite) mem[MemAddress[16:2]] <= MemWriteData;
   end

   assign MemReadData = mem[MemAddress[16:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [14:0] idx, input logic [31:0] val);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge Clk); #1;
      pre_en = 1'b0;
   endtask

   // Called just after a negedge with the arbiter idle; returns after a negedge in IDLE.
   task automatic xfer(input bit n, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      if (n == 1'b0) begin Req0 = 1'b1; We0 = we; Addr0 = addr; WData0 = wdata; end
      else           begin Req1 = 1'b1; We1 = we; Addr1 = addr; WData1 = wdata; end
      @(posedge Clk);
      @(negedge Clk);
      acc_rd = MemRead; acc_wr = MemWrite; acc_addr = MemAddress; acc_busy = Busy;
      mw_cyc = int'(MemWrite);
      @(posedge Clk); #1;
      Req0 = 1'b0; Req1 = 1'b0;
      @(negedge Clk);
      r_ack0 = Ack0; r_ack1 = Ack1; r_err0 = Err0; r_err1 = Err1;
      r_rdata0 = RData0; r_rdata1 = RData1;
      mw_cyc += int'(MemWrite);
      @(posedge Clk);
      @(negedge Clk);
      idle_busy = Busy; idle_ack = {Ack0, Ack1};
      mw_cyc += int'(MemWrite);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and memory preload
      preload(15'd0, 32'h2222_2222);
      preload(15'd1, 32'h1111_1111);
      preload(15'd4, 32'hDEAD_BEEF);
      preload(15'd8, 32'h55AA_55AA);
      @(negedge Clk);
      chk("reset_ctrl", {25'd0, Ack0, Ack1, Err0, Err1, MemWrite, MemRead, Busy}, 32'h0);
      chk("reset_rdata0", RData0, 32'h0);
      chk("reset_rdata1", RData1, 32'h0);
      chk("reset_memaddr", MemAddress, 32'h0);
      chk("reset_memwdata", MemWriteData, 32'h0);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("idle_busy", Busy, 32'h0);

      // Basic read of word 4
      xfer(1'b0, 1'b0, 32'h10, 32'h0);
      chk("rd_mem_rw", {30'd0, acc_rd, acc_wr}, 32'h2);
      chk("rd_mem_addr", acc_addr, 32'h10);
      chk("rd_busy", acc_busy, 32'h1);
      chk("rd_ack", {28'd0, r_ack0, r_err0, r_ack1, r_err1}, 32'h8);
      chk("rd_rdata0", r_rdata0, 32'hDEAD_BEEF);
      chk("rd_idle", {29'd0, idle_busy, idle_ack}, 32'h0);

      // Round-robin with both requesters held high after reset
      Reset_n = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin ev_who[i] = 9; ev_cyc[i] = -1; end
      n_ev = 0; both_seen = 0;
      Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h10;
      Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'h10;
      for (int c = 1; c <= 14; c++) begin
         @(negedge Clk);
         if (Ack0 && Ack1) both_seen++;
         if (Ack0 && n_ev < 8) begin ev_who[n_ev] = 0; ev_cyc[n_ev] = c; n_ev++; end
         if (Ack1 && n_ev < 8) begin ev_who[n_ev] = 1; ev_cyc[n_ev] = c; n_ev++; end
         if (c == 11) begin Req0 = 1'b0; Req1 = 1'b0; end
      end
      chk("rr_count", 32'(n_ev), 32'd4);
      chk("rr_both", 32'(both_seen), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_who%0d", i), 32'(ev_who[i]), 32'(i % 2));
         chk($sformatf("rr_cyc%0d", i), 32'(ev_cyc[i]), 32'(2 + 3 * i));
      end
      chk("rr_rdata1", RData1, 32'hDEAD_BEEF);

      // Write to the last word, then read it back
      xfer(1'b1, 1'b1, 32'h1FFFC, 32'h1234_5678);
      chk("wr_mw_cycles", 32'(mw_cyc), 32'd1);
      chk("wr_mem_addr", acc_addr, 32'h1FFFC);
      chk("wr_ack", {28'd0, r_ack0, r_err0, r_ack1, r_err1}, 32'h2);
      chk("wr_rdata1_hold", r_rdata1, 32'hDEAD_BEEF);
      chk("wr_mem_word", mem[32767], 32'h1234_5678);
      xfer(1'b0, 1'b0, 32'h1FFFC, 32'h0);
      chk("rb_rdata0", r_rdata0, 32'h1234_5678);
      chk("rb_ack", {28'd0, r_ack0, r_err0, r_ack1, r_err1}, 32'h8);

      // Rejected accesses: misaligned, out of range, rejected read
      xfer(1'b0, 1'b1, 32'h6, 32'hBAD0_BAD0);
      chk("mis_ack", {28'd0, r_ack0, r_err0, r_ack1, r_err1}, 32'hC);
      chk("mis_mw_cycles", 32'(mw_cyc), 32'd0);
      chk("mis_rdata0_hold", r_rdata0, 32'h1234_5678);
      xfer(1'b0, 1'b1, 32'h20000, 32'hBAD1_BAD1);
      chk("oor_ack", {28'd0, r_ack0, r_err0, r_ack1, r_err1}, 32'hC);
      chk("oor_mw_cycles", 32'(mw_cyc), 32'd0);
      chk("rej_mem1", mem[1], 32'h1111_1111);
      chk("rej_mem0", mem[0], 32'h2222_2222);
      xfer(1'b0, 1'b0, 32'h22, 32'h0);
      chk("rejrd_memread", {31'd0, acc_rd}, 32'h0);
      chk("rejrd_ack", {28'd0, r_ack0, r_err0, r_ack1, r_err1}, 32'hC);
      chk("rejrd_rdata0", r_rdata0, 32'h0);

      // Reset pulse during the ACCESS cycle of a write
      Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'h20; WData0 = 32'hCAFE_F00D;
      @(posedge Clk); #2;
      chk("rst_mw_before", {31'd0, MemWrite}, 32'h1);
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_mw_after", {30'd0, MemWrite, Busy}, 32'h0);
      chk("rst_memaddr", MemAddress, 32'h0);
      Req0 = 1'b0;
      ack_cnt = 0;
      @(negedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      if (Ack0 || Ack1) ack_cnt++;
      Reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         if (Ack0 || Ack1) ack_cnt++;
      end
      chk("rst_no_ack", 32'(ack_cnt), 32'd0);
      chk("rst_mem8", mem[8], 32'h55AA_55AA);
      chk("rst_idle", {31'd0, Busy}, 32'h0);
      Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h10;
      Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'h10;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      chk("rst_tie_ack", {30'd0, Ack0, Ack1}, 32'h2);
      Req0 = 1'b0; Req1 = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      chk("rst_tie_idle", {31'd0, Busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
